// File: rtl/alu_pkg.sv
// Shared constants for the execute/write-back stage: widths, opcodes, FSM states.
package alu_pkg;

    localparam int ALU_XLEN       = 32;
    localparam int ALU_AW         = 5;
    localparam int ALU_MUL_CYCLES = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/seq_mul32.sv
// Iterative shift-add multiplier: one partial-product add per cycle, low XLEN bits kept.
module seq_mul32 #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] mcand_i,
    input  logic [XLEN-1:0] mplr_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplr_q, mplr_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic [XLEN-1:0] acc_sum_s;

    // The final add is exposed combinationally so the caller can capture it on the last edge.
    assign acc_sum_s = acc_q + (mplr_q[0] ? mcand_q : {XLEN{1'b0}});
    assign done_o    = busy_q && (cnt_q == LAST);
    assign result_o  = acc_sum_s;

    // Next-state for the shift-add datapath.
    always_comb begin
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (start_i) begin
            mcand_d = mcand_i;
            mplr_d  = mplr_i;
            acc_d   = {XLEN{1'b0}};
            cnt_d   = {CW{1'b0}};
            busy_d  = 1'b1;
        end else if (busy_q) begin
            acc_d   = acc_sum_s;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            busy_d  = (cnt_q != LAST);
        end else begin
            busy_d  = 1'b0;
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q <= {XLEN{1'b0}};
            mplr_q  <= {XLEN{1'b0}};
            acc_q   <= {XLEN{1'b0}};
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: rtl/alu_wb_pipe.sv
// Execute/write-back stage for the 32x32 register file: ALU, write-back forwarding,
// and a stalling iterative multiplier.
module alu_wb_pipe
    import alu_pkg::*;
#(
    parameter int XLEN       = ALU_XLEN,
    parameter int AW         = ALU_AW,
    parameter int MUL_CYCLES = ALU_MUL_CYCLES
) (
    input  logic            m_clock,
    input  logic            p_reset,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [3:0]      op,
    input  logic [AW-1:0]   rs_a,
    input  logic [AW-1:0]   rs_b,
    input  logic [AW-1:0]   rd,
    input  logic [15:0]     imm,
    input  logic            use_imm,
    output logic            rf_read_a,
    output logic            rf_read_b,
    output logic [AW-1:0]   rf_a_addr,
    output logic [AW-1:0]   rf_b_addr,
    input  logic [XLEN-1:0] rf_a,
    input  logic [XLEN-1:0] rf_b,
    output logic            rf_write,
    output logic [AW-1:0]   rf_in_addr,
    output logic [XLEN-1:0] rf_in,
    output logic            rf_clear,
    output logic            err_illegal,
    output logic [15:0]     retired
);

    state_e          state_q, state_d;
    logic            wb_valid_q, wb_valid_d;
    logic [AW-1:0]   wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [AW-1:0]   mul_rd_q, mul_rd_d;
    logic            err_q, err_d;
    logic [15:0]     retired_q, retired_d;

    logic            accept_s;
    logic            mul_start_s;
    logic            mul_done_s;
    logic [XLEN-1:0] mul_result_s;
    logic [XLEN-1:0] imm_ext_s;
    logic [XLEN-1:0] op_a_s;
    logic [XLEN-1:0] op_b_s;
    logic [XLEN-1:0] alu_res_s;
    logic            illegal_s;

    assign issue_ready = (state_q == IDLE);
    assign accept_s    = issue_valid && issue_ready;
    assign rf_read_a   = accept_s;
    assign rf_read_b   = accept_s;
    assign rf_a_addr   = rs_a;
    assign rf_b_addr   = rs_b;
    assign rf_write    = wb_valid_q;
    assign rf_in_addr  = wb_rd_q;
    assign rf_in       = wb_data_q;
    assign rf_clear    = 1'b0;
    assign err_illegal = err_q;
    assign retired     = retired_q;

    // The regfile returns stale data for the register being written this cycle; forward instead.
    assign imm_ext_s = {{(XLEN-16){imm[15]}}, imm};
    assign op_a_s    = (wb_valid_q && (wb_rd_q == rs_a)) ? wb_data_q : rf_a;
    assign op_b_s    = use_imm ? imm_ext_s
                     : ((wb_valid_q && (wb_rd_q == rs_b)) ? wb_data_q : rf_b);

    // Single-cycle ALU; MUL goes to the iterative unit and 12-15 are flagged illegal.
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        illegal_s = 1'b0;
        case (op)
            OP_ADD:  alu_res_s = op_a_s + op_b_s;
            OP_SUB:  alu_res_s = op_a_s - op_b_s;
            OP_AND:  alu_res_s = op_a_s & op_b_s;
            OP_OR:   alu_res_s = op_a_s | op_b_s;
            OP_XOR:  alu_res_s = op_a_s ^ op_b_s;
            OP_SLL:  alu_res_s = op_a_s << op_b_s[4:0];
            OP_SRL:  alu_res_s = op_a_s >> op_b_s[4:0];
            OP_SRA:  alu_res_s = $signed(op_a_s) >>> op_b_s[4:0];
            OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
            OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
            OP_MUL:  alu_res_s = {XLEN{1'b0}};
            OP_LUI:  alu_res_s = {imm, {(XLEN-16){1'b0}}};
            default: illegal_s = 1'b1;
        endcase
    end

    seq_mul32 #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk_i    (m_clock),
        .rst_i    (p_reset),
        .start_i  (mul_start_s),
        .mcand_i  (op_a_s),
        .mplr_i   (op_b_s),
        .done_o   (mul_done_s),
        .result_o (mul_result_s)
    );

    // Issue/stall FSM and write-back register next-state.
    always_comb begin
        state_d     = state_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        mul_rd_d    = mul_rd_q;
        err_d       = 1'b0;
        mul_start_s = 1'b0;
        retired_d   = wb_valid_q ? (retired_q + 16'd1) : retired_q;
        case (state_q)
            IDLE: begin
                if (accept_s && illegal_s) begin
                    err_d = 1'b1;
                end else if (accept_s && (op == OP_MUL)) begin
                    mul_start_s = 1'b1;
                    mul_rd_d    = rd;
                    state_d     = MUL;
                end else if (accept_s) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd;
                    wb_data_d  = alu_res_s;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (mul_done_s) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = mul_rd_q;
                    wb_data_d  = mul_result_s;
                    state_d    = IDLE;
                end else begin
                    state_d = MUL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage registers.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= {AW{1'b0}};
            wb_data_q  <= {XLEN{1'b0}};
            mul_rd_q   <= {AW{1'b0}};
            err_q      <= 1'b0;
            retired_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            mul_rd_q   <= mul_rd_d;
            err_q      <= err_d;
            retired_q  <= retired_d;
        end
    end

endmodule
